key_debounce: RTL and testbench

Debounces one raw mechanical push-button input and produces clean single-cycle event pulses for the counting and display logic downstream. It sits directly upstream of the key-driven counter: that stage consumes `key_pulse` as its increment strobe. Optional auto-repeat while the key is held lets the counter step continuously without repeated presses.

---
 rtl/key_debounce.sv | 159 +++++++++++++++
 tb/tb_key_debounce.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// key_debounce: turns one raw, bouncing push-button into clean strobes.
// The raw level is synchronised, normalised to "pressed", then a 4-state
// debouncer accepts a level change only after DEBOUNCE_CYCLES consecutive
// agreeing samples. While the key is held, an optional hold/repeat timer
// emits further key_pulse strobes.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned KEY_ACTIVE_LOW  = 1,
  parameter int unsigned REPEAT_EN       = 0,
  parameter int unsigned HOLD_CYCLES     = 25000000,
  parameter int unsigned REPEAT_CYCLES   = 5000000
) (
  input  logic clk,
  input  logic rst,          // asynchronous, active low
  input  logic key,
  output logic key_pulse,
  output logic key_release,
  output logic key_state
);

  // Raw level of the key when nobody touches it.
  localparam logic KEY_IDLE = (KEY_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  // Stable counter only ever needs to reach DEBOUNCE_CYCLES-2: the sample
  // taken in IDLE/PRESSED counts as the first agreeing sample.
  localparam int unsigned CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

  localparam int unsigned HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic [1:0]        sync_reg;
  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [HOLD_W-1:0] hold_reg;
  logic              repeating_reg;
  logic              key_pulse_reg;
  logic              key_release_reg;
  logic              key_state_reg;

  logic pressed;
  logic cnt_done;
  logic hold_done;

  // Two-flop synchroniser; resets to the released level so a key held
  // through reset is seen as a fresh press afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg <= {KEY_IDLE, KEY_IDLE};
    end else begin
      sync_reg <= {sync_reg[0], key};
    end
  end

  assign pressed   = sync_reg[1] ^ KEY_IDLE;
  assign cnt_done  = (cnt_reg == CNT_LAST);
  assign hold_done = repeating_reg ? (hold_reg == REP_LAST) : (hold_reg == HOLD_LAST);

  // Debounce FSM with hold/repeat timer; all outputs are registered here.
  // The hold timer advances on every cycle the debounced key is down and
  // the synchronised key reads pressed, so cycles spent checking a possible
  // release simply freeze it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      hold_reg        <= '0;
      repeating_reg   <= 1'b0;
      key_pulse_reg   <= 1'b0;
      key_release_reg <= 1'b0;
      key_state_reg   <= 1'b0;
    end else begin
      key_pulse_reg   <= 1'b0;
      key_release_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pressed) begin
            state_reg <= PRESS_WAIT;
            cnt_reg   <= '0;
          end
        end

        PRESS_WAIT: begin
          if (!pressed) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end else if (cnt_done) begin
            state_reg     <= PRESSED;
            cnt_reg       <= '0;
            key_pulse_reg <= 1'b1;
            key_state_reg <= 1'b1;
            hold_reg      <= '0;
            repeating_reg <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        PRESSED: begin
          if (!pressed) begin
            state_reg <= RELEASE_WAIT;
            cnt_reg   <= '0;
          end else if (REPEAT_EN != 0) begin
            if (hold_done) begin
              key_pulse_reg <= 1'b1;
              hold_reg      <= '0;
              repeating_reg <= 1'b1;
            end else begin
              hold_reg <= hold_reg + HOLD_W'(1);
            end
          end
        end

        RELEASE_WAIT: begin
          if (pressed) begin
            // Bounce rejected: back to held, timer resumes where it froze.
            state_reg <= PRESSED;
            cnt_reg   <= '0;
            if (REPEAT_EN != 0) begin
              if (hold_done) begin
                key_pulse_reg <= 1'b1;
                hold_reg      <= '0;
                repeating_reg <= 1'b1;
              end else begin
                hold_reg <= hold_reg + HOLD_W'(1);
              end
            end
          end else if (cnt_done) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            key_release_reg <= 1'b1;
            key_state_reg   <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  assign key_pulse   = key_pulse_reg;
  assign key_release = key_release_reg;
  assign key_state   = key_state_reg;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: two instances (auto-repeat off / on) share one
// key stimulus. A behavioural model tracks, per instance, the run of
// samples disagreeing with the debounced level and the held-time count.
module tb_key_debounce;

  localparam int D = 4;
  localparam int H = 10;
  localparam int R = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic key = 1'b1;

  logic [1:0] dut_pulse;
  logic [1:0] dut_rel;
  logic [1:0] dut_state;

  always #5 clk = ~clk;

  key_debounce #(
    .DEBOUNCE_CYCLES(D), .KEY_ACTIVE_LOW(1), .REPEAT_EN(0),
    .HOLD_CYCLES(H), .REPEAT_CYCLES(R)
  ) u_norep (
    .clk(clk), .rst(rst), .key(key),
    .key_pulse(dut_pulse[0]), .key_release(dut_rel[0]), .key_state(dut_state[0])
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(D), .KEY_ACTIVE_LOW(1), .REPEAT_EN(1),
    .HOLD_CYCLES(H), .REPEAT_CYCLES(R)
  ) u_rep (
    .clk(clk), .rst(rst), .key(key),
    .key_pulse(dut_pulse[1]), .key_release(dut_rel[1]), .key_state(dut_state[1])
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state
  logic       raw_q[$];            // raw key samples, oldest first
  logic [1:0] exp_pulse, exp_rel, exp_state;
  int         m_run[2], m_hold[2], m_target[2];

  // Observed-strobe bookkeeping for directed timing checks
  int n_p[2], n_r[2], last_p[2], last_r[2];
  int rep_q[$];

  // One clock edge of the model: the key value seen two edges ago decides.
  task automatic model_step();
    logic p;
    if (!rst) begin
      raw_q.delete();
      raw_q.push_back(1'b1);
      raw_q.push_back(1'b1);
      exp_pulse = '0;
      exp_rel   = '0;
      exp_state = '0;
      for (int i = 0; i < 2; i++) begin
        m_run[i] = 0; m_hold[i] = 0; m_target[i] = H;
      end
    end else begin
      p = ~raw_q.pop_front();
      raw_q.push_back(key);
      for (int i = 0; i < 2; i++) begin
        exp_pulse[i] = 1'b0;
        exp_rel[i]   = 1'b0;
        if (p != exp_state[i]) m_run[i]++;
        else m_run[i] = 0;
        if (m_run[i] == D) begin
          m_run[i] = 0;
          exp_state[i] = p;
          if (p) begin
            exp_pulse[i] = 1'b1;
            m_hold[i] = 0;
            m_target[i] = H;
          end else begin
            exp_rel[i] = 1'b1;
          end
        end else if (i == 1 && exp_state[i] && p) begin
          m_hold[i]++;
          if (m_hold[i] == m_target[i]) begin
            exp_pulse[i] = 1'b1;
            m_hold[i] = 0;
            m_target[i] = R;
          end
        end
      end
    end
  endtask

  // Advance one cycle, compare all outputs of both instances on the falling edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    model_step();
    for (int i = 0; i < 2; i++) begin
      checks++;
      assert (dut_pulse[i] === exp_pulse[i]) else begin
        errors++;
        $error("FAIL key_pulse[%0d] cyc=%0d got=%b want=%b", i, cyc, dut_pulse[i], exp_pulse[i]);
      end
      checks++;
      assert (dut_rel[i] === exp_rel[i]) else begin
        errors++;
        $error("FAIL key_release[%0d] cyc=%0d got=%b want=%b", i, cyc, dut_rel[i], exp_rel[i]);
      end
      checks++;
      assert (dut_state[i] === exp_state[i]) else begin
        errors++;
        $error("FAIL key_state[%0d] cyc=%0d got=%b want=%b", i, cyc, dut_state[i], exp_state[i]);
      end
      if (dut_pulse[i] === 1'b1) begin
        n_p[i]++;
        last_p[i] = cyc;
        if (i == 1) rep_q.push_back(cyc);
        $display("cyc %0d: inst%0d key_pulse", cyc, i);
      end
      if (dut_rel[i] === 1'b1) begin
        n_r[i]++;
        last_r[i] = cyc;
        $display("cyc %0d: inst%0d key_release", cyc, i);
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 2; i++) begin
      n_p[i] = 0; n_r[i] = 0; last_p[i] = -1; last_r[i] = -1;
    end
    rep_q.delete();
  endtask

  task automatic check_val(input string tag, input int got, input int want);
    checks++;
    assert (got == want) else begin
      errors++;
      $error("FAIL %s got=%0d want=%0d", tag, got, want);
    end
    $display("check %s: got %0d want %0d", tag, got, want);
  endtask

  int t0, t1, a, b, d, r;

  initial begin
    clear_counts();

    // Reset held while the key toggles: everything stays quiet.
    rst = 1'b0;
    repeat (8) begin
      key = ~key;
      tick();
    end
    key = 1'b1;
    run(2);
    check_val("reset_quiet_pulse", n_p[0] + n_p[1], 0);
    check_val("reset_quiet_release", n_r[0] + n_r[1], 0);
    rst = 1'b1;
    clear_counts();
    run(10);
    check_val("post_reset_no_pulse", n_p[0] + n_p[1], 0);
    check_val("post_reset_no_release", n_r[0] + n_r[1], 0);

    // Clean press, hold 20, clean release.
    clear_counts();
    key = 1'b0; t0 = cyc;
    run(20);
    key = 1'b1; t1 = cyc;
    run(12);
    check_val("clean_press_count", n_p[0], 1);
    check_val("clean_press_latency", last_p[0] - t0, 6);
    check_val("clean_release_count", n_r[0], 1);
    check_val("clean_release_latency", last_r[0] - t1, 6);

    // Bounce on press, then bounce on release.
    run(4);
    clear_counts();
    key = 1'b0; run(3);
    key = 1'b1; run(1);
    key = 1'b0; t0 = cyc;
    run(12);
    check_val("bounce_press_count", n_p[0], 1);
    check_val("bounce_press_latency", last_p[0] - t0, 6);
    key = 1'b1; run(3);
    key = 1'b0; run(1);
    key = 1'b1; t1 = cyc;
    run(12);
    check_val("bounce_release_count", n_r[0], 1);
    check_val("bounce_release_latency", last_r[0] - t1, 6);

    // Auto-repeat: held 30 cycles past acceptance.
    run(4);
    clear_counts();
    key = 1'b0; a = cyc;
    run(36);
    key = 1'b1;
    run(14);
    check_val("repeat_count", rep_q.size(), 9);
    check_val("repeat_first_latency", rep_q[0] - a, 6);
    check_val("repeat_hold_gap", rep_q[1] - rep_q[0], 10);
    check_val("repeat_gap_1", rep_q[2] - rep_q[1], 3);
    check_val("repeat_gap_2", rep_q[3] - rep_q[2], 3);
    check_val("repeat_release_count", n_r[1], 1);
    check_val("repeat_none_after_release", (last_p[1] > last_r[1]) ? 1 : 0, 0);
    check_val("norep_single_pulse", n_p[0], 1);

    // Short release glitch while held delays the first repeat by 2.
    run(4);
    clear_counts();
    key = 1'b0; b = cyc;
    run(11);
    key = 1'b1; run(2);
    key = 1'b0;
    run(20);
    check_val("glitch_no_release_rep", n_r[1], 0);
    check_val("glitch_no_release_norep", n_r[0], 0);
    check_val("glitch_press_latency", rep_q[0] - b, 6);
    check_val("glitch_delayed_repeat", rep_q[1] - rep_q[0], 12);
    key = 1'b1;
    run(12);

    // Reset two cycles into PRESS_WAIT with the key held down.
    run(4);
    clear_counts();
    key = 1'b0; d = cyc;
    run(5);
    rst = 1'b0;
    run(3);
    check_val("mid_reset_no_pulse", n_p[0] + n_p[1], 0);
    rst = 1'b1; r = cyc;
    clear_counts();
    run(15);
    check_val("after_reset_pulse_count", n_p[0], 1);
    check_val("after_reset_pulse_latency", last_p[0] - r, 6);
    check_val("after_reset_pulse_count_rep", n_p[1], 1);
    key = 1'b1;
    run(12);

    // Random bouncing, checked cycle by cycle against the model.
    repeat (60) begin
      key = 1'($urandom_range(0, 1));
      run($urandom_range(1, 9));
    end
    key = 1'b1;
    run(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
